cond_exec_stage: RTL
====================

// Module: cond_exec_stage
// PURPOSE
//  Execute-stage conditional-execution unit of the pipelined CPU control path. Registers decode-stage control into E.
//  Holds the architectural NZCV flags register and evaluates the ARM condition field against it.
//  Gates RegWrite/MemWrite/PCSrc of annulled instructions and updates flags from the ALU per FlagW.
//  Keeps saturating executed/annulled instruction counters for debug.
// PARAMETERS
//  CNT_W  16  width of the executed/annulled counters (saturating)
// PORTS
//  clk          in   1      system clock; all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  stall_e      in   1      hold E register and flags; no counter update
//  flush_e      in   1      load bubble into E register (priority over stall_e)
//  valid_d      in   1      decode slot holds a real instruction
//  cond_d       in   4      instruction condition field [31:28]
//  flag_w_d     in   2      [1]=write N,Z  [0]=write C,V
//  pc_src_d     in   1      instruction writes PC / branches
//  reg_write_d  in   1      instruction writes register file
//  mem_write_d  in   1      instruction writes memory
//  no_write_d   in   1      compare-class op: suppress reg write even if executed
//  alu_flags_e  in   4      ALU result flags {N,Z,C,V}, combinational in E
//  pc_src_e     out  1      gated PC write
//  reg_write_e  out  1      gated register write
//  mem_write_e  out  1      gated memory write
//  cond_ex_e    out  1      condition passed AND valid_e
//  flags_q      out  4      architectural flags {N,Z,C,V}
//  exec_cnt     out  CNT_W  count of executed (cond passed) instructions
//  annul_cnt    out  CNT_W  count of valid instructions whose condition failed
// BEHAVIOUR
//  Reset: E register cleared (valid_e=0, all ctrl 0, cond_e=4'b1110); flags_q=0; both counters=0.
//   All gated outputs 0 in the cycle after reset.
//  E register, per edge (reset dominates):
//   flush_e=1 -> bubble (valid_e=0, ctrl 0), regardless of stall_e.
//   else stall_e=1 -> hold. else load *_d.
//  Condition (combinational on cond_e vs flags_q):
//   0000 EQ Z | 0001 NE ~Z | 0010 CS C | 0011 CC ~C
//   0100 MI N | 0101 PL ~N | 0110 VS V | 0111 VC ~V
//   1000 HI C&~Z | 1001 LS ~(C&~Z) | 1010 GE N==V | 1011 LT N!=V
//   1100 GT ~Z&(N==V) | 1101 LE ~(~Z&(N==V)) | 1110 AL 1
//   1111 -> fails (0); never X.
//  cond_ex_e = valid_e & pass.
//  Gating: pc_src_e = pc_src_e_q & cond_ex_e; mem_write_e = mem_write_e_q & cond_ex_e.
//   reg_write_e = reg_write_e_q & cond_ex_e & ~no_write_e.
//  Flags update at edge when cond_ex_e & ~stall_e & ~reset:
//   flag_w_e[1] -> N,Z from alu_flags_e[3:2]; flag_w_e[0] -> C,V from alu_flags_e[1:0].
//   Halves independent; unwritten half holds.
//  Flags written by instr k are visible to instr k+1 in its E cycle (no bypass needed; one E stage).
//   A flag-setting instruction does not see its own result.
//  Counters, when valid_e & ~stall_e: exec_cnt++ if cond_ex_e, else annul_cnt++.
//   Saturate at all-ones; no wrap.
//  flush_e and stall_e do not affect flags/counters for the instruction being flushed from D; the E-resident
//   instruction still commits unless stall_e=1.
//  Reset mid-stall or mid-flush: reset wins, state per reset values next cycle.
// TESTING
//  1) flags_q=0100 (Z), cond EQ, reg_write -> reg_write_e=1, exec_cnt=1.
//     Then cond NE -> reg_write_e=0, annul_cnt=1.
//  2) CMP (flag_w=11, no_write=1, alu_flags=1000), then BLT (cond 1011, pc_src) next cycle
//     -> reg_write_e=0 on CMP, flags_q=1000, pc_src_e=1 on BLT.
//  3) flags_q=1111, flag_w=10, alu_flags=0000, AL -> flags_q=0011 (C,V held).
//  4) stall_e=1 for 3 cycles with flag-setting AL instr in E -> flags and counters change once, only after stall drops.
//     flush_e with stall_e -> valid_e=0 next cycle.
//  5) Sweep all 16 cond x 16 flag values vs reference table; cond 1111 always 0, outputs never X.
//  6) Preload exec_cnt to all-ones via CNT_W=2 build, execute 5 AL instr -> exec_cnt=3.
//     Assert reset mid-stream -> all outputs/counters 0.

Source files
------------

// File: rtl/cond_exec_stage.sv
// cond_exec_stage: execute-stage condition evaluation against the NZCV flags,
// gating of annulled writes, flag update from the ALU and saturating debug counters.
module cond_exec_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             valid_d,
    input  logic [3:0]       cond_d,
    input  logic [1:0]       flag_w_d,
    input  logic             pc_src_d,
    input  logic             reg_write_d,
    input  logic             mem_write_d,
    input  logic             no_write_d,
    input  logic [3:0]       alu_flags_e,
    output logic             pc_src_e,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             cond_ex_e,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] annul_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             valid_e_q;
    logic [3:0]       cond_e_q;
    logic [1:0]       flag_w_e_q;
    logic             pc_src_e_q;
    logic             reg_write_e_q;
    logic             mem_write_e_q;
    logic             no_write_e_q;
    logic [CNT_W-1:0] exec_cnt_q;
    logic [CNT_W-1:0] annul_cnt_q;
    logic             n, z, c, v;
    logic             pass;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        pass = 1'b0;
        case (cond_e_q)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~(c & ~z);
            4'b1010: pass = n == v;
            4'b1011: pass = n != v;
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = ~(~z & (n == v));
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    assign cond_ex_e   = valid_e_q & pass;
    assign pc_src_e    = pc_src_e_q & cond_ex_e;
    assign mem_write_e = mem_write_e_q & cond_ex_e;
    assign reg_write_e = reg_write_e_q & cond_ex_e & ~no_write_e_q;
    assign exec_cnt    = exec_cnt_q;
    assign annul_cnt   = annul_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e_q     <= 1'b0;
            cond_e_q      <= 4'b1110;
            flag_w_e_q    <= 2'b00;
            pc_src_e_q    <= 1'b0;
            reg_write_e_q <= 1'b0;
            mem_write_e_q <= 1'b0;
            no_write_e_q  <= 1'b0;
            flags_q       <= 4'b0000;
            exec_cnt_q    <= '0;
            annul_cnt_q   <= '0;
        end else begin
            if (flush_e) begin
                valid_e_q     <= 1'b0;
                cond_e_q      <= 4'b1110;
                flag_w_e_q    <= 2'b00;
                pc_src_e_q    <= 1'b0;
                reg_write_e_q <= 1'b0;
                mem_write_e_q <= 1'b0;
                no_write_e_q  <= 1'b0;
            end else if (!stall_e) begin
                valid_e_q     <= valid_d;
                cond_e_q      <= cond_d;
                flag_w_e_q    <= flag_w_d;
                pc_src_e_q    <= pc_src_d;
                reg_write_e_q <= reg_write_d;
                mem_write_e_q <= mem_write_d;
                no_write_e_q  <= no_write_d;
            end
            // the E-resident instruction commits even while D is being flushed
            if (cond_ex_e && !stall_e) begin
                if (flag_w_e_q[1]) flags_q[3:2] <= alu_flags_e[3:2];
                if (flag_w_e_q[0]) flags_q[1:0] <= alu_flags_e[1:0];
            end
            if (valid_e_q && !stall_e) begin
                if (cond_ex_e) begin
                    if (exec_cnt_q != CNT_MAX) exec_cnt_q <= exec_cnt_q + CNT_W'(1);
                end else begin
                    if (annul_cnt_q != CNT_MAX) annul_cnt_q <= annul_cnt_q + CNT_W'(1);
                end
            end
        end
    end
endmodule
